mrv1_retire_mw: RTL and testbench

Multi-writeback, round-robin retirement unit for the multithreaded core, placed between the functional units and the register file.
- Each thread has a completion buffer indexed by instruction tag.
- Each cycle the unit picks one ready thread and retires its in-order completed instructions.
- It retires up to `MAX_RET_P` instructions and issues up to `NUM_WB_P` register writes per cycle, through a registered output stage with regfile backpressure.

---
 rtl/mrv1_retire_mw.sv | 192 +++++++++++++++++++
 tb/tb_mrv1_retire_mw.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mrv1_retire_mw.sv
// mrv1_retire_mw: round-robin, multi-writeback retirement unit.
// Per-thread completion buffers feed an in-order scan. Each cycle one thread
// retires up to MAX_RET_P instructions and up to NUM_WB_P register writes
// through a registered output stage that honours regfile backpressure.
// Optional feature: define MRV1_RETIRE_BYPASS_EN to let the scan see
// same-cycle FU completions, which saves a cycle of latency at the cost of a
// longer FU-to-output timing path.
module mrv1_retire_mw #(
  parameter int NUM_TW_P        = 8,
  parameter int DATA_WIDTH_P    = 32,
  parameter int ITAG_WIDTH_P    = 4,
  parameter int RF_ADDR_WIDTH_P = 5,
  parameter int NUM_FU_P        = 6,
  parameter int NUM_WB_P        = 2,
  parameter int MAX_RET_P       = 4,
  localparam int IQ_DEPTH = 2 ** ITAG_WIDTH_P,
  localparam int TWID_W   = $clog2(NUM_TW_P),
  localparam int CNT_W    = $clog2(MAX_RET_P + 1)
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_i,
  input  logic [NUM_FU_P-1:0]                                     fu_done_i,
  input  logic [NUM_FU_P-1:0][TWID_W-1:0]                         fu_twid_i,
  input  logic [NUM_FU_P-1:0][ITAG_WIDTH_P-1:0]                   fu_itag_i,
  input  logic [NUM_FU_P-1:0][DATA_WIDTH_P-1:0]                   fu_wb_data_i,
  input  logic [NUM_TW_P-1:0][ITAG_WIDTH_P-1:0]                   iq_head_i,
  input  logic [NUM_TW_P-1:0][ITAG_WIDTH_P:0]                     iq_cnt_i,
  input  logic [NUM_TW_P-1:0][IQ_DEPTH-1:0]                       iq_rd_vld_i,
  input  logic [NUM_TW_P-1:0][IQ_DEPTH-1:0][RF_ADDR_WIDTH_P-1:0]  iq_rd_addr_i,
  input  logic                                                    wb_rdy_i,
  output logic                                                    retire_vld_o,
  output logic [TWID_W-1:0]                                       retire_twid_o,
  output logic [CNT_W-1:0]                                        retire_cnt_o,
  output logic [NUM_WB_P-1:0]                                     wb_vld_o,
  output logic [NUM_WB_P-1:0][RF_ADDR_WIDTH_P-1:0]                wb_rd_addr_o,
  output logic [NUM_WB_P-1:0][DATA_WIDTH_P-1:0]                   wb_data_o
);

  logic [NUM_TW_P-1:0][IQ_DEPTH-1:0] vld_q, set_mask, clr_mask, view_vld;
  logic [DATA_WIDTH_P-1:0]           data_q      [NUM_TW_P][IQ_DEPTH];
  logic [DATA_WIDTH_P-1:0]           merged_data [NUM_TW_P][IQ_DEPTH];
  logic [DATA_WIDTH_P-1:0]           view_data   [NUM_TW_P][IQ_DEPTH];
  logic                              dup_hit;
  logic [NUM_TW_P-1:0][CNT_W-1:0]    scan_cnt;
  logic [NUM_TW_P-1:0]               ready, lock_q;
  logic [TWID_W-1:0]                 last_q, grant_tw;
  logic                              grant_vld, accept;
  logic [NUM_WB_P-1:0]                      nxt_wb_vld;
  logic [NUM_WB_P-1:0][RF_ADDR_WIDTH_P-1:0] nxt_rd_addr;
  logic [NUM_WB_P-1:0][DATA_WIDTH_P-1:0]    nxt_data;

  // Decode FU completions into set bits and merged data; higher FU index wins a collision.
  always_comb begin
    set_mask = '0;
    dup_hit  = 1'b0;
    for (int t = 0; t < NUM_TW_P; t++)
      for (int e = 0; e < IQ_DEPTH; e++)
        merged_data[t][e] = data_q[t][e];
    for (int j = 0; j < NUM_FU_P; j++) begin
      if (fu_done_i[j]) begin
        set_mask[fu_twid_i[j]][fu_itag_i[j]]    = 1'b1;
        merged_data[fu_twid_i[j]][fu_itag_i[j]] = fu_wb_data_i[j];
        for (int i = 0; i < j; i++)
          if (fu_done_i[i] && fu_twid_i[i] == fu_twid_i[j] && fu_itag_i[i] == fu_itag_i[j])
            dup_hit = 1'b1;
      end
    end
  end

  // Select what the scan sees: registered buffer only, or buffer merged with this cycle's completions.
  always_comb begin
`ifdef MRV1_RETIRE_BYPASS_EN
    view_vld  = vld_q | set_mask;
    view_data = merged_data;
`else
    view_vld  = vld_q;
    view_data = data_q;
`endif
  end

  // Per-thread in-order scan: count retirable entries from the head under all stop rules.
  always_comb begin
    int n;
    int w;
    logic stop;
    logic [ITAG_WIDTH_P-1:0] tag;
    scan_cnt = '0;
    ready    = '0;
    for (int t = 0; t < NUM_TW_P; t++) begin
      n    = 0;
      w    = 0;
      stop = 1'b0;
      for (int k = 0; k < MAX_RET_P; k++) begin
        tag = iq_head_i[t] + ITAG_WIDTH_P'(k);
        if (!stop) begin
          if (!view_vld[t][tag] || (ITAG_WIDTH_P+1)'(k) >= iq_cnt_i[t]) begin
            stop = 1'b1;
          end else if (iq_rd_vld_i[t][tag] && w == NUM_WB_P) begin
            stop = 1'b1;
          end else begin
            n = n + 1;
            if (iq_rd_vld_i[t][tag]) w = w + 1;
          end
        end
      end
      scan_cnt[t] = CNT_W'(n);
      ready[t]    = (n != 0);
    end
  end

  // Round-robin arbiter: first ready, unlocked thread after last; stalls while the output is blocked.
  always_comb begin
    int idx;
    accept    = !retire_vld_o || wb_rdy_i;
    grant_vld = 1'b0;
    grant_tw  = '0;
    for (int i = 1; i <= NUM_TW_P; i++) begin
      idx = (int'(last_q) + i) % NUM_TW_P;
      if (!grant_vld && accept && ready[idx] && !lock_q[idx]) begin
        grant_vld = 1'b1;
        grant_tw  = TWID_W'(idx);
      end
    end
  end

  // Build the retire group for the granted thread: clear mask and oldest-first port packing.
  always_comb begin
    int p;
    logic [ITAG_WIDTH_P-1:0] tag;
    clr_mask    = '0;
    nxt_wb_vld  = '0;
    nxt_rd_addr = '0;
    nxt_data    = '0;
    p           = 0;
    for (int k = 0; k < MAX_RET_P; k++) begin
      tag = iq_head_i[grant_tw] + ITAG_WIDTH_P'(k);
      if (grant_vld && CNT_W'(k) < scan_cnt[grant_tw]) begin
        clr_mask[grant_tw][tag] = 1'b1;
        if (iq_rd_vld_i[grant_tw][tag] && p < NUM_WB_P) begin
          nxt_wb_vld[p]  = 1'b1;
          nxt_rd_addr[p] = iq_rd_addr_i[grant_tw][tag];
          nxt_data[p]    = view_data[grant_tw][tag];
          p = p + 1;
        end
      end
    end
  end

  // Buffer data needs no reset; valid bits alone decide what is live.
  always_ff @(posedge clk_i) begin
    data_q <= merged_data;
  end

  // Valid bits, arbiter state and the registered output stage; retirement clears win over sets.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q         <= '0;
      last_q        <= '0;
      lock_q        <= '0;
      retire_vld_o  <= 1'b0;
      retire_twid_o <= '0;
      retire_cnt_o  <= '0;
      wb_vld_o      <= '0;
      wb_rd_addr_o  <= '0;
      wb_data_o     <= '0;
    end else begin
      vld_q  <= (vld_q | set_mask) & ~clr_mask;
      lock_q <= '0;
      if (grant_vld) begin
        last_q           <= grant_tw;
        lock_q[grant_tw] <= 1'b1;
        retire_vld_o     <= 1'b1;
        retire_twid_o    <= grant_tw;
        retire_cnt_o     <= scan_cnt[grant_tw];
        wb_vld_o         <= nxt_wb_vld;
        wb_rd_addr_o     <= nxt_rd_addr;
        wb_data_o        <= nxt_data;
      end else if (wb_rdy_i) begin
        retire_vld_o  <= 1'b0;
        retire_twid_o <= '0;
        retire_cnt_o  <= '0;
        wb_vld_o      <= '0;
        wb_rd_addr_o  <= '0;
        wb_data_o     <= '0;
      end
    end
  end

  // Two FUs completing the same thread/tag in one cycle is a protocol violation.
  assert property (@(posedge clk_i) disable iff (rst_i) !dup_hit);

endmodule

// File: tb/tb_mrv1_retire_mw.sv
// tb_mrv1_retire_mw: directed bench for mrv1_retire_mw with a reference model
// of the retirement rules and a per-cycle compare process.
module tb_mrv1_retire_mw;

  localparam int NT   = 8;
  localparam int DEP  = 16;
  localparam int NFU  = 6;
  localparam int NWB  = 2;
  localparam int MAXR = 4;
`ifdef MRV1_RETIRE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic rst;
  logic [NFU-1:0]            fu_done;
  logic [NFU-1:0][2:0]       fu_twid;
  logic [NFU-1:0][3:0]       fu_itag;
  logic [NFU-1:0][31:0]      fu_data;
  logic [NT-1:0][3:0]        iq_head;
  logic [NT-1:0][4:0]        iq_cnt;
  logic [NT-1:0][DEP-1:0]    iq_rd_vld;
  logic [NT-1:0][DEP-1:0][4:0] iq_rd_addr;
  logic                      wb_rdy;
  logic                      retire_vld_o;
  logic [2:0]                retire_twid_o;
  logic [2:0]                retire_cnt_o;
  logic [NWB-1:0]            wb_vld_o;
  logic [NWB-1:0][4:0]       wb_rd_addr_o;
  logic [NWB-1:0][31:0]      wb_data_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  mrv1_retire_mw dut (
    .clk_i(clk), .rst_i(rst),
    .fu_done_i(fu_done), .fu_twid_i(fu_twid), .fu_itag_i(fu_itag), .fu_wb_data_i(fu_data),
    .iq_head_i(iq_head), .iq_cnt_i(iq_cnt), .iq_rd_vld_i(iq_rd_vld), .iq_rd_addr_i(iq_rd_addr),
    .wb_rdy_i(wb_rdy),
    .retire_vld_o(retire_vld_o), .retire_twid_o(retire_twid_o), .retire_cnt_o(retire_cnt_o),
    .wb_vld_o(wb_vld_o), .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: completed set per thread plus the expected output stage.
  bit          mv [NT][DEP];
  logic [31:0] md [NT][DEP];
  bit          nv [NT][DEP];
  logic [31:0] nd [NT][DEP];
  bit          vv [NT][DEP];
  logic [31:0] vd [NT][DEP];
  int m_last, m_lock;
  bit e_vld;
  int e_tw, e_cnt;
  logic [NWB-1:0] e_wbv;
  logic [4:0]  e_addr [NWB];
  logic [31:0] e_data [NWB];
  bit cons_vld;
  int cons_tw, cons_cnt;

  // How many instructions thread t could retire now, walking program order from its head.
  function automatic int groupSize(input int t);
    int n = 0;
    int w = 0;
    for (int i = 0; i < MAXR; i++) begin
      int tag;
      tag = (iq_head[t] + i) % DEP;
      if (i >= int'(iq_cnt[t]) || !vv[t][tag]) break;
      if (iq_rd_vld[t][tag]) begin
        if (w == NWB) break;
        w++;
      end
      n++;
    end
    return n;
  endfunction

  always @(posedge clk) begin : ref_model
    int g, n, tag, p;
    if (rst) begin
      foreach (mv[t, e]) mv[t][e] = 1'b0;
      m_last = 0; m_lock = -1;
      e_vld = 0; e_tw = 0; e_cnt = 0; e_wbv = '0;
      e_addr = '{default: '0}; e_data = '{default: '0};
      cons_vld = 0;
    end else begin
      cons_vld = e_vld && wb_rdy; cons_tw = e_tw; cons_cnt = e_cnt;
      nv = mv; nd = md;
      for (int j = 0; j < NFU; j++)
        if (fu_done[j]) begin
          nv[fu_twid[j]][fu_itag[j]] = 1'b1;
          nd[fu_twid[j]][fu_itag[j]] = fu_data[j];
        end
`ifdef MRV1_RETIRE_BYPASS_EN
      vv = nv; vd = nd;
`else
      vv = mv; vd = md;
`endif
      g = -1;
      if (!e_vld || wb_rdy)
        for (int off = 1; off <= NT; off++)
          if (g < 0 && ((m_last + off) % NT) != m_lock && groupSize((m_last + off) % NT) > 0)
            g = (m_last + off) % NT;
      if (g >= 0) begin
        n = groupSize(g);
        e_wbv = '0; e_addr = '{default: '0}; e_data = '{default: '0};
        p = 0;
        for (int i = 0; i < n; i++) begin
          tag = (iq_head[g] + i) % DEP;
          nv[g][tag] = 1'b0;
          if (iq_rd_vld[g][tag]) begin
            e_wbv[p] = 1'b1; e_addr[p] = iq_rd_addr[g][tag]; e_data[p] = vd[g][tag];
            p++;
          end
        end
        e_vld = 1; e_tw = g; e_cnt = n; m_last = g; m_lock = g;
      end else begin
        m_lock = -1;
        if (cons_vld) begin
          e_vld = 0; e_tw = 0; e_cnt = 0; e_wbv = '0;
          e_addr = '{default: '0}; e_data = '{default: '0};
        end
      end
      mv = nv; md = nd;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model every cycle once out of initial reset.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_retire_vld", retire_vld_o, e_vld);
      checkOutput("cmp_wb_vld", wb_vld_o, e_wbv);
      if (e_vld) begin
        checkOutput("cmp_twid", retire_twid_o, e_tw);
        checkOutput("cmp_cnt", retire_cnt_o, e_cnt);
      end
      for (int p = 0; p < NWB; p++)
        if (e_wbv[p]) begin
          checkOutput($sformatf("cmp_addr%0d", p), wb_rd_addr_o[p], e_addr[p]);
          checkOutput($sformatf("cmp_data%0d", p), wb_data_o[p], e_data[p]);
        end
    end
  end

  // One cycle: wait for the next negedge, drop strobes, and advance the emulated IQ on consumption.
  task automatic tick();
    @(negedge clk);
    fu_done = '0;
    if (cons_vld) begin
      iq_head[cons_tw] = iq_head[cons_tw] + 4'(cons_cnt);
      iq_cnt[cons_tw]  = iq_cnt[cons_tw] - 5'(cons_cnt);
    end
  endtask

  task automatic applyStimulus(input int j, input int tw, input int tag, input logic [31:0] d);
    fu_done[j] = 1'b1;
    fu_twid[j] = 3'(tw);
    fu_itag[j] = 4'(tag);
    fu_data[j] = d;
  endtask

  task automatic doReset();
    rst = 1'b1;
    fu_done = '0; fu_twid = '0; fu_itag = '0; fu_data = '0;
    iq_head = '0; iq_cnt = '0; iq_rd_vld = '0; iq_rd_addr = '0;
    wb_rdy = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic waitGroup(input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!retire_vld_o && n < 8);
    checkOutput({name, "_arrived"}, retire_vld_o, 1'b1);
  endtask

  initial begin
    int lat, rep, stall_seen;
    int seq[$];
    int exp_rr[6] = '{1, 2, 6, 1, 2, 6};

    doReset();
    tick();
    checkOutput("reset_vld", retire_vld_o, 0);
    checkOutput("reset_twid", retire_twid_o, 0);
    checkOutput("reset_cnt", retire_cnt_o, 0);
    checkOutput("reset_wb_vld", wb_vld_o, 0);
    checkOutput("reset_addr", wb_rd_addr_o, 0);
    checkOutput("reset_data", wb_data_o, 0);
    cmp_en = 1;

    // Single instruction, thread 3, head 5.
    doReset();
    iq_head[3] = 4'd5; iq_cnt[3] = 5'd1; iq_rd_vld[3][5] = 1'b1; iq_rd_addr[3][5] = 5'd7;
    applyStimulus(0, 3, 5, 32'hDEAD);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!retire_vld_o && lat < 6);
    checkOutput("single_latency", lat, LAT);
    checkOutput("single_twid", retire_twid_o, 3);
    checkOutput("single_cnt", retire_cnt_o, 1);
    checkOutput("single_wb_vld", wb_vld_o, 2'b01);
    checkOutput("single_addr", wb_rd_addr_o[0], 7);
    checkOutput("single_data", wb_data_o[0], 32'hDEAD);
    checkOutput("single_model_cnt", e_cnt, 1);
    checkOutput("single_model_data", e_data[0], 32'hDEAD);
    tick();

    // Port limit: four writers on thread 0.
    doReset();
    iq_cnt[0] = 5'd4; iq_rd_vld[0] = 16'h000F;
    for (int k = 0; k < 4; k++) begin
      iq_rd_addr[0][k] = 5'(k + 1);
      applyStimulus(k, 0, k, 32'h100 + k);
    end
    waitGroup("plim_g1");
    checkOutput("plim_g1_cnt", retire_cnt_o, 2);
    checkOutput("plim_g1_wbv", wb_vld_o, 2'b11);
    checkOutput("plim_g1_addr1", wb_rd_addr_o[1], 2);
    checkOutput("plim_g1_data0", wb_data_o[0], 32'h100);
    checkOutput("plim_model_cnt", e_cnt, 2);
    waitGroup("plim_g2");
    checkOutput("plim_g2_cnt", retire_cnt_o, 2);
    checkOutput("plim_g2_addr0", wb_rd_addr_o[0], 3);
    checkOutput("plim_g2_data1", wb_data_o[1], 32'h103);

    // Port limit variant: entries 1 and 3 do not write.
    doReset();
    iq_cnt[0] = 5'd4; iq_rd_vld[0] = 16'b0101;
    iq_rd_addr[0][0] = 5'd10; iq_rd_addr[0][2] = 5'd12;
    for (int k = 0; k < 4; k++) applyStimulus(k, 0, k, 32'h200 + k);
    waitGroup("mix");
    checkOutput("mix_cnt", retire_cnt_o, 4);
    checkOutput("mix_wbv", wb_vld_o, 2'b11);
    checkOutput("mix_addr0", wb_rd_addr_o[0], 10);
    checkOutput("mix_addr1", wb_rd_addr_o[1], 12);
    checkOutput("mix_data1", wb_data_o[1], 32'h202);
    tick();

    // Round robin and lockout: threads 1, 2, 6 fully completed, released together.
    doReset();
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < NFU; j++) begin
        int idx;
        idx = c * NFU + j;
        applyStimulus(j, (idx < 16) ? 1 : (idx < 32) ? 2 : 6, idx % 16, 32'h3000 + idx);
      end
      tick();
    end
    iq_cnt[1] = 5'd16; iq_cnt[2] = 5'd16; iq_cnt[6] = 5'd16;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (retire_vld_o) seq.push_back(int'(retire_twid_o));
    end
    checkOutput("rr_groups", seq.size(), 12);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("rr_grant%0d", i), (i < seq.size()) ? seq[i] : -1, exp_rr[i]);
    rep = 0;
    for (int i = 1; i < seq.size(); i++) if (seq[i] == seq[i-1]) rep++;
    checkOutput("rr_no_repeat", rep, 0);

    // Tag wrap: head 15 scans into tags 0 and 1.
    doReset();
    iq_head[5] = 4'd15; iq_cnt[5] = 5'd3;
    iq_rd_vld[5][15] = 1'b1; iq_rd_addr[5][15] = 5'd20;
    iq_rd_vld[5][0]  = 1'b1; iq_rd_addr[5][0]  = 5'd21;
    applyStimulus(0, 5, 15, 32'hF15);
    applyStimulus(1, 5, 0, 32'hF00);
    applyStimulus(2, 5, 1, 32'hF01);
    waitGroup("wrap");
    checkOutput("wrap_cnt", retire_cnt_o, 3);
    checkOutput("wrap_addr0", wb_rd_addr_o[0], 20);
    checkOutput("wrap_addr1", wb_rd_addr_o[1], 21);
    checkOutput("wrap_data0", wb_data_o[0], 32'hF15);
    checkOutput("wrap_data1", wb_data_o[1], 32'hF00);
    tick();

    // Backpressure: group held for three cycles while another completion is buffered.
    doReset();
    wb_rdy = 1'b0;
    iq_cnt[4] = 5'd1; iq_rd_vld[4][0] = 1'b1; iq_rd_addr[4][0] = 5'd9;
    applyStimulus(1, 4, 0, 32'hA5);
    waitGroup("bp");
    iq_cnt[2] = 5'd1; iq_rd_vld[2][0] = 1'b1; iq_rd_addr[2][0] = 5'd11;
    applyStimulus(0, 2, 0, 32'h77);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("bp_hold_vld%0d", c), retire_vld_o, 1);
      checkOutput($sformatf("bp_hold_twid%0d", c), retire_twid_o, 4);
      checkOutput($sformatf("bp_hold_data%0d", c), wb_data_o[0], 32'hA5);
    end
    wb_rdy = 1'b1;
    tick();
    checkOutput("bp_next_twid", retire_twid_o, 2);
    checkOutput("bp_next_addr", wb_rd_addr_o[0], 11);
    checkOutput("bp_next_data", wb_data_o[0], 32'h77);
    tick();

    // Reset while a group is pending: everything drops, nothing old retires later.
    doReset();
    wb_rdy = 1'b0;
    iq_cnt[6] = 5'd1; iq_rd_vld[6][0] = 1'b1; iq_rd_addr[6][0] = 5'd3;
    iq_cnt[1] = 5'd1; iq_rd_vld[1][0] = 1'b1; iq_rd_addr[1][0] = 5'd4;
    applyStimulus(0, 6, 0, 32'h66);
    applyStimulus(1, 1, 0, 32'h11);
    waitGroup("rst_mid");
    checkOutput("rst_mid_pre_twid", retire_twid_o, 1);
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_vld", retire_vld_o, 0);
    checkOutput("rst_mid_twid", retire_twid_o, 0);
    checkOutput("rst_mid_cnt", retire_cnt_o, 0);
    checkOutput("rst_mid_wbv", wb_vld_o, 0);
    checkOutput("rst_mid_addr", wb_rd_addr_o, 0);
    checkOutput("rst_mid_data", wb_data_o, 0);
    rst = 1'b0;
    wb_rdy = 1'b1;
    stall_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (retire_vld_o) stall_seen++;
    end
    checkOutput("rst_mid_no_stale", stall_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
